alu_exec_mc: RTL and testbench

ALU_EXEC_MC -- requirements
Module: alu_exec_mc

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_op_decode.sv | 44 ++++
 rtl/alu_exec_mc.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_mc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: alu_op, funct codes, FSM states, internal op enum.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ILL   = 2'b11
  } alu_op_e;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLLV, OP_SRLV, OP_SRAV, OP_MULTU, OP_NONE
  } op_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SLLV) || (op == OP_SRLV) || (op == OP_SRAV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op/funct into the internal op enum plus an illegal flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output op_e        o_op,
  output logic       o_illegal
);

  op_e w_op;

  always_comb begin
    w_op = OP_NONE;
    case (alu_op_e'(i_alu_op))
      ALU_ADD: w_op = OP_ADD;
      ALU_SUB: w_op = OP_SUB;
      ALU_FUNCT: begin
        case (i_funct)
          F_ADD:   w_op = OP_ADD;
          F_SUB:   w_op = OP_SUB;
          F_AND:   w_op = OP_AND;
          F_OR:    w_op = OP_OR;
          F_XOR:   w_op = OP_XOR;
          F_NOR:   w_op = OP_NOR;
          F_SLT:   w_op = OP_SLT;
          F_SLTU:  w_op = OP_SLTU;
          F_SLLV:  w_op = OP_SLLV;
          F_SRLV:  w_op = OP_SRLV;
          F_SRAV:  w_op = OP_SRAV;
          F_MULTU: w_op = MUL_EN ? OP_MULTU : OP_NONE;
          default: w_op = OP_NONE;
        endcase
      end
      default: w_op = OP_NONE;
    endcase
  end

  assign o_op      = w_op;
  assign o_illegal = (w_op == OP_NONE);

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts and shift-add multu behind a valid/ready FSM.
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  state_e r_state, w_state_nxt;
  op_e    w_op, r_op;
  logic   w_illegal;

  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc, w_step;
  logic [WIDTH:0]     w_mac;
  logic [CW-1:0]      r_cnt;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_sum, w_dif, w_res;
  logic               w_ovf, w_accept, w_direct, w_last;

  logic             r_out_valid, r_zero, r_ovf, r_illegal;
  logic [WIDTH-1:0] r_result, r_result_hi;

  alu_op_decode #(.MUL_EN(MUL_EN)) u_dec (
    .i_alu_op  (alu_op),
    .i_funct   (funct),
    .o_op      (w_op),
    .o_illegal (w_illegal)
  );

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = b[SHW-1:0];
  assign w_sum    = a + b;
  assign w_dif    = a - b;
  assign w_direct = !((w_op == OP_MULTU) || (is_shift(w_op) && (w_shamt != '0)));
  assign w_last   = (r_cnt == CW'(1));

  // Results for ops that finish straight out of IDLE (zero-length shifts pass a through)
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLLV, OP_SRLV, OP_SRAV: w_res = a;
      default: w_res = '0;
    endcase
  end

  // One iteration: shifts move the low word one bit, multu adds-and-shifts the product register
  assign w_mac = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  always_comb begin
    w_step = r_acc;
    case (r_op)
      OP_SLLV:  w_step = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], 1'b0};
      OP_SRLV:  w_step = {r_acc[2*WIDTH-1:WIDTH], 1'b0, r_acc[WIDTH-1:1]};
      OP_SRAV:  w_step = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      OP_MULTU: w_step = {w_mac, r_acc[WIDTH-1:1]};
      default:  w_step = r_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_state_nxt = w_direct ? S_DONE : S_BUSY;
      end
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= OP_NONE;
      r_a         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= w_op;
          r_a   <= a;
          r_acc <= {{WIDTH{1'b0}}, (w_op == OP_MULTU) ? b : a};
          r_cnt <= (w_op == OP_MULTU) ? CW'(WIDTH) : CW'(w_shamt);
          if (w_direct) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_zero      <= (w_res == '0);
            r_ovf       <= w_ovf;
            r_illegal   <= w_illegal;
          end
        end
        S_BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_step[WIDTH-1:0];
            r_result_hi <= (r_op == OP_MULTU) ? w_step[2*WIDTH-1:WIDTH] : '0;
            r_zero      <= (w_step[WIDTH-1:0] == '0);
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed vector bench for alu_exec_mc: table of ops plus stall, reset-abort and MUL_EN=0 sequences.
module tb_alu_exec_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, in_ready, out_valid;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a, b, result, result_hi;
  logic         zero, ovf, illegal;

  logic         in_valid0, out_ready0, in_ready0, out_valid0;
  logic [W-1:0] result0, result_hi0;
  logic         zero0, ovf0, illegal0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .ovf(ovf), .illegal(illegal)
  );

  alu_exec_mc #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
    .result_hi(result_hi0), .zero(zero0), .ovf(ovf0), .illegal(illegal0)
  );

  typedef struct {
    logic [1:0]   op;
    logic [5:0]   f;
    logic [W-1:0] a, b, res, hi;
    logic         z, o, ill;
    int           lat;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge with the DUT idle
  task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, output int lat, output logic [W-1:0] r,
                        output logic [W-1:0] rh, output logic z, output logic o, output logic ill);
    alu_op = op; funct = f; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    r = result; rh = result_hi; z = zero; o = ovf; ill = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [W-1:0] r, rh;
    logic z, o, ill;

    vt[0]  = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vt[1]  = '{2'b01, 6'b000000, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vt[2]  = '{2'b00, 6'b111111, 32'h00000003, 32'h00000004, 32'h00000007, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[3]  = '{2'b00, 6'b000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vt[4]  = '{2'b01, 6'b000000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vt[5]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[6]  = '{2'b10, 6'b100101, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[7]  = '{2'b10, 6'b100110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[8]  = '{2'b10, 6'b100111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[9]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[10] = '{2'b10, 6'b101011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vt[11] = '{2'b10, 6'b000100, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 32};
    vt[12] = '{2'b10, 6'b000110, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 5};
    vt[13] = '{2'b10, 6'b000111, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 5};
    vt[14] = '{2'b10, 6'b000111, 32'h80000000, 32'h00000000, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vt[15] = '{2'b10, 6'b000111, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 5};
    vt[16] = '{2'b10, 6'b011001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 33};
    vt[17] = '{2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
    vt[18] = '{2'b10, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1};
    vt[19] = '{2'b11, 6'b100000, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1, 1};
    vt[20] = '{2'b10, 6'b011001, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 33};
    vt[21] = '{2'b10, 6'b000100, 32'h00000003, 32'h00000001, 32'h00000006, 32'h0, 1'b0, 1'b0, 1'b0, 2};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    alu_op = 2'b00; funct = 6'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_result_hi", 64'(result_hi), 64'd0);
    chk("rst_flags", 64'({zero, ovf, illegal}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      run_op(vt[i].op, vt[i].f, vt[i].a, vt[i].b, lat, r, rh, z, o, ill);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_result", i), 64'(r), 64'(vt[i].res));
      chk($sformatf("v%0d_result_hi", i), 64'(rh), 64'(vt[i].hi));
      chk($sformatf("v%0d_zero", i), 64'(z), 64'(vt[i].z));
      chk($sformatf("v%0d_ovf", i), 64'(o), 64'(vt[i].o));
      chk($sformatf("v%0d_illegal", i), 64'(ill), 64'(vt[i].ill));
    end

    // Stall in DONE while offering a different op that must be ignored
    alu_op = 2'b01; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 2'b00; a = 32'd1; b = 32'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_result", k), 64'(result), 64'd0);
      chk($sformatf("stall%0d_flags", k), 64'({zero, ovf, illegal}), 64'b100);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("stall_release_out_valid", 64'(out_valid), 64'd0);
    chk("stall_release_in_ready", 64'(in_ready), 64'd1);

    // Reset aborts a multu in flight
    alu_op = 2'b10; funct = 6'b011001; a = 32'hFFFFFFFF; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    chk("post_abort_in_ready", 64'(in_ready), 64'd1);
    run_op(2'b00, 6'b0, 32'd3, 32'd4, lat, r, rh, z, o, ill);
    chk("post_abort_latency", 64'(lat), 64'd1);
    chk("post_abort_result", 64'(r), 64'd7);

    // MUL_EN=0 instance rejects multu
    chk("nomul_in_ready", 64'(in_ready0), 64'd1);
    alu_op = 2'b10; funct = 6'b011001; a = 32'h7; b = 32'h9; in_valid0 = 1'b1;
    @(posedge clk); #1 in_valid0 = 1'b0;
    @(negedge clk);
    chk("nomul_out_valid", 64'(out_valid0), 64'd1);
    chk("nomul_illegal", 64'(illegal0), 64'd1);
    chk("nomul_result", 64'({result_hi0, result0}), 64'd0);
    out_ready0 = 1'b1;
    @(posedge clk); #1 out_ready0 = 1'b0;
    @(negedge clk);
    chk("nomul_release", 64'(out_valid0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
